// File: rtl/nios2_pio_pkg.sv
// rtl/nios2_pio_pkg.sv - shared register map constants and helpers for the Nios2 input PIO
package nios2_pio_pkg;

   localparam int PIO_MAX_WIDTH = 32;

   localparam logic [2:0] PIO_ADDR_DATA     = 3'd0;
   localparam logic [2:0] PIO_ADDR_RAW      = 3'd1;
   localparam logic [2:0] PIO_ADDR_IRQ_MASK = 3'd2;
   localparam logic [2:0] PIO_ADDR_EDGE     = 3'd3;
   localparam logic [2:0] PIO_ADDR_RISE_EN  = 3'd4;
   localparam logic [2:0] PIO_ADDR_FALL_EN  = 3'd5;

   // Write-1-to-clear update where a simultaneous set always wins over the clear
   function automatic logic [PIO_MAX_WIDTH-1:0] pio_w1c(
      input logic [PIO_MAX_WIDTH-1:0] cur,
      input logic [PIO_MAX_WIDTH-1:0] clr,
      input logic [PIO_MAX_WIDTH-1:0] set
   );
      return (cur & ~clr) | set;
   endfunction

endpackage

// File: rtl/nios2_pio_debounce_bit.sv
// rtl/nios2_pio_debounce_bit.sv - one-bit 2-FF synchroniser plus debouncer; counter present only with NIOS2_PIO_IN_DEBOUNCE_EN
module nios2_pio_debounce_bit
`ifdef NIOS2_PIO_IN_DEBOUNCE_EN
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
)
`endif
(
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_in,
   output logic o_sync,
   output logic o_stable
);

   logic r_meta;
   logic r_sync;

   // Two-flop synchroniser for the asynchronous pin
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_in;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

`ifdef NIOS2_PIO_IN_DEBOUNCE_EN
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_stable;

   // Accept a change only after it has persisted for DEBOUNCE_CYCLES cycles;
   // the counter can only leave its range through the accept branch
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else if (r_sync == r_stable) begin
         r_cnt    <= '0;
      end else if (r_cnt == C_LAST) begin
         r_stable <= r_sync;
         r_cnt    <= '0;
      end else begin
         r_cnt    <= r_cnt + CNT_W'(1);
      end
   end

   assign o_stable = r_stable;
`else
   assign o_stable = r_sync;
`endif

endmodule

// File: rtl/nios2_debounced_pio_in.sv
// rtl/nios2_debounced_pio_in.sv - Avalon-MM debounced input PIO with edge capture and IRQ; debounce built only with NIOS2_PIO_IN_DEBOUNCE_EN
module nios2_debounced_pio_in
   import nios2_pio_pkg::*;
#(
   parameter int WIDTH           = 18,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
)(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [2:0]       i_address,
   input  logic             i_chipselect,
   input  logic             i_write_n,
   input  logic [31:0]      i_writedata,
   output logic [31:0]      o_readdata,
   input  logic [WIDTH-1:0] i_in_port,
   output logic             o_irq
);

   logic [WIDTH-1:0] w_sync;
   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] w_wdata;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_clr;
   logic             w_wr;
   logic [31:0]      w_rdata;
   logic             w_unused_wdata;

   logic [WIDTH-1:0] r_stable_d;
   logic [WIDTH-1:0] r_irq_mask;
   logic [WIDTH-1:0] r_edge;
   logic [WIDTH-1:0] r_rise_en;
   logic [WIDTH-1:0] r_fall_en;
   logic [31:0]      r_readdata;
   logic             r_irq;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      nios2_pio_debounce_bit
`ifdef NIOS2_PIO_IN_DEBOUNCE_EN
      #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      )
`endif
      u_bit (
         .i_clk    (i_clk),
         .i_reset  (i_reset),
         .i_in     (i_in_port[g]),
         .o_sync   (w_sync[g]),
         .o_stable (w_stable[g])
      );
   end

`ifndef NIOS2_PIO_IN_DEBOUNCE_EN
   // Debounce timing parameters have no effect when the counters are not built
   logic w_unused_cfg;
   assign w_unused_cfg = (DEBOUNCE_CYCLES > 0) && (CNT_W > 0);
`endif

   // Upper write-data bits beyond WIDTH are don't-care
   assign w_unused_wdata = ^i_writedata;

   assign w_wr    = i_chipselect & ~i_write_n;
   assign w_wdata = i_writedata[WIDTH-1:0];
   assign w_rise  =  w_stable & ~r_stable_d & r_rise_en;
   assign w_fall  = ~w_stable &  r_stable_d & r_fall_en;
   assign w_clr   = (w_wr && i_address == PIO_ADDR_EDGE) ? w_wdata : '0;

   // Delayed copy of the debounced value for edge detection
   always_ff @(posedge i_clk) begin
      if (i_reset) r_stable_d <= '0;
      else         r_stable_d <= w_stable;
   end

   // Read/write configuration registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_irq_mask <= '0;
         r_rise_en  <= '1;
         r_fall_en  <= '0;
      end else if (w_wr) begin
         if (i_address == PIO_ADDR_IRQ_MASK) r_irq_mask <= w_wdata;
         if (i_address == PIO_ADDR_RISE_EN)  r_rise_en  <= w_wdata;
         if (i_address == PIO_ADDR_FALL_EN)  r_fall_en  <= w_wdata;
      end
   end

   // Edge capture: sticky until written with 1, a same-cycle event is never lost
   always_ff @(posedge i_clk) begin
      if (i_reset) r_edge <= '0;
      else         r_edge <= WIDTH'(pio_w1c(PIO_MAX_WIDTH'(r_edge),
                                            PIO_MAX_WIDTH'(w_clr),
                                            PIO_MAX_WIDTH'(w_rise | w_fall)));
   end

   // Read mux, independent of chipselect; unmapped addresses read zero
   always_comb begin
      w_rdata = '0;
      case (i_address)
         PIO_ADDR_DATA:     w_rdata = 32'(w_stable);
         PIO_ADDR_RAW:      w_rdata = 32'(w_sync);
         PIO_ADDR_IRQ_MASK: w_rdata = 32'(r_irq_mask);
         PIO_ADDR_EDGE:     w_rdata = 32'(r_edge);
         PIO_ADDR_RISE_EN:  w_rdata = 32'(r_rise_en);
         PIO_ADDR_FALL_EN:  w_rdata = 32'(r_fall_en);
         default:           w_rdata = '0;
      endcase
   end

   // Registered read data and level interrupt
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_readdata <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_readdata <= w_rdata;
         r_irq      <= |(r_edge & r_irq_mask);
      end
   end

   assign o_readdata = r_readdata;
   assign o_irq      = r_irq;

endmodule
